mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller for the 16-bit single-cycle MIPS core.
- Sequences a radix-2 shift-add multiplier and a restoring divider, then writes the HI/LO pair that mfhi/mflo read.
- Drives the core's instruction stall select so the PC and fetch hold while an operation is in flight.
- Raises a one-cycle ready pulse when HI/LO are updated.

Parameters:
WIDTH, 16, operand width; HI and LO are each WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request from decode; sampled only in IDLE.
op  input  2  00 multu, 01 divu, 10 mult (signed), 11 div (signed).
a  input  WIDTH  rs operand / dividend.
b  input  WIDTH  rt operand / divisor.
hi  output  WIDTH  product upper half, or remainder.
lo  output  WIDTH  product lower half, or quotient.
busy  output  1  high in RUN and FIX.
instr_stall_sl  output  1  stall to the core: (IDLE & start) | busy, combinational.
ready  output  1  registered one-cycle pulse after HI/LO are written.
div_zero  output  1  sticky flag, set by a divide with b==0, cleared by the next accepted start.

Behaviour:
- Reset:
  - state=IDLE; hi, lo, ready, div_zero, counter and working registers all go to 0.
  - Reset asserted mid-operation aborts the operation; HI/LO are not written with a partial result.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On start=1 (edge E0), latch op, |a|, |b| and the sign bits. Magnitudes are taken only for signed ops; unsigned ops use raw values.
  - Then clear the accumulator, set counter=0, clear div_zero, and go to RUN.
- RUN (edges E1..E16 for WIDTH=16): one iteration per cycle; counter increments.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper accumulator (WIDTH+1 bits, carry kept), then shift the {acc, multiplier} pair right by 1.
  - Divide (restoring): shift {rem, quot} left by 1, trial-subtract the divisor from rem (WIDTH+1 bits). If non-negative, keep the difference and set quot LSB=1; otherwise restore rem and set quot LSB=0.
  - When counter==WIDTH-1, go to FIX.
- FIX (edge E17): sign correction, then write hi/lo; ready<=1; state<=IDLE.
  - mult: negate the 2*WIDTH product if sign_a^sign_b.
  - div: negate the quotient if sign_a^sign_b; negate the remainder if sign_a (truncation toward zero).
  - Divide by zero (b==0, either signedness): lo=all ones, hi=a (the original, un-negated a), div_zero=1. The full WIDTH iterations still run, so latency is constant.
- Latency: HI/LO are valid and ready=1 in the cycle after E17 (WIDTH+2 edges after the start edge). instr_stall_sl is high for WIDTH+2 cycles total and is low in the ready cycle.
- ready is high exactly one cycle. A start in that same cycle is accepted (back-to-back operation).
- start while busy is ignored. It does not restart, queue, or change the operands.
- HI/LO hold their previous values throughout RUN/FIX and are updated only at FIX.
- Inputs a, b, op may change after E0 without affecting the result.
- Signed corner case: 0x8000 * 0x8000 = 0x40000000 (the magnitude 0x8000 is handled in the WIDTH+1-bit datapath).

Test Plan:
- multu a=300, b=500 -> after 18 edges hi=0x0002, lo=0x49F0, ready pulses once; instr_stall_sl high for exactly 18 cycles.
- mult a=0xFFFD (-3), b=7 -> hi=0xFFFF, lo=0xFFEB; separately a=0x8000, b=0x8000 -> hi=0x4000, lo=0x0000.
- divu a=100, b=7 -> lo=14, hi=2. div a=0xFF9C (-100), b=7 -> lo=0xFFF2 (-14), hi=0xFFFE (-2).
- divu a=1234, b=0 -> lo=0xFFFF, hi=0x04D2, div_zero=1. The next multu start clears div_zero on the start edge.
- Busy and back-to-back:
  - multu 2*3 starts; toggle start and change a/b during RUN -> result still hi=0, lo=6.
  - Assert start with divu 9/2 during the ready cycle -> accepted, giving lo=4, hi=1 after 18 more edges.
- Reset mid-operation: reset=1 at RUN iteration 8 -> next edge state=IDLE, hi=lo=0, busy=0, instr_stall_sl=0; no ready pulse follows.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the 16-bit MIPS core.
// Radix-2 shift-add multiplier and restoring divider share one datapath;
// signed ops run on magnitudes and are sign-corrected in FIX before HI/LO
// are written. The core stalls fetch on instr_stall_sl while a job runs.
module mdu_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             instr_stall_sl,
  output logic             ready,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sgn_a, sgn_b;   // only set for signed ops
  logic               b_zero;
  logic [WIDTH-1:0]   a_orig;         // un-negated dividend for the /0 result
  logic [WIDTH-1:0]   opnd;           // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   low;            // multiplier / quotient shift register
  logic [WIDTH:0]     acc;            // upper accumulator / remainder, carry kept

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, shl;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy           = (state == RUN) || (state == FIX);
  assign instr_stall_sl = ((state == IDLE) && start) || busy;

  // Operand magnitudes, one iteration of each algorithm, and sign fix-up
  always_comb begin
    mag_a    = (op[1] && a[WIDTH-1]) ? -a : a;
    mag_b    = (op[1] && b[WIDTH-1]) ? -b : b;
    add_sum  = acc + (low[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shl      = {acc[WIDTH-1:0], low[WIDTH-1]};
    diff     = {1'b0, shl} - {2'b00, opnd};
    prod     = {acc[WIDTH-1:0], low};
    prod_fix = (sgn_a ^ sgn_b) ? -prod : prod;
    quo_fix  = (sgn_a ^ sgn_b) ? -low : low;
    rem_fix  = sgn_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  // Sequencer FSM: latch operands, iterate WIDTH times, correct and commit
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      b_zero   <= 1'b0;
      a_orig   <= '0;
      opnd     <= '0;
      low      <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[0];
            sgn_a    <= op[1] & a[WIDTH-1];
            sgn_b    <= op[1] & b[WIDTH-1];
            a_orig   <= a;
            b_zero   <= (b == '0);
            low      <= mag_a;
            opnd     <= mag_b;
            acc      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            if (!diff[WIDTH+1]) begin
              acc <= diff[WIDTH:0];
              low <= {low[WIDTH-2:0], 1'b1};
            end else begin
              acc <= shl;
              low <= {low[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {1'b0, add_sum[WIDTH:1]};
            low <= {add_sum[0], low[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (b_zero) begin
            hi       <= a_orig;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus pushes expected HI/LO/div_zero,
// a monitor pops and compares on every ready pulse.
module tb_mdu_sequencer;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [15:0] a, b, hi, lo;
  logic        busy, instr_stall_sl, ready, div_zero;

  typedef struct {
    logic [15:0] h;
    logic [15:0] l;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   stall_n;

  mdu_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .instr_stall_sl(instr_stall_sl),
    .ready(ready), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hi", {16'h0, hi}, {16'h0, e.h});
        chk("lo", {16'h0, lo}, {16'h0, e.l});
        chk("div_zero", {31'h0, div_zero}, {31'h0, e.dz});
      end
    end
  end

  // Drive a request through the start edge; callers are always mid-cycle
  task automatic start_op(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb,
                          input bit push, input logic [15:0] eh, input logic [15:0] el,
                          input logic edz);
    exp_t e;
    if (push) begin
      e.h = eh; e.l = el; e.dz = edz;
      exp_q.push_back(e);
    end
    op = o; a = va; b = vb; start = 1'b1;
    #1;
    stall_n = instr_stall_sl ? 1 : 0;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Wait for ready (bounded), counting stall cycles; returns at the ready negedge
  task automatic wait_ready();
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready) begin
        got = 1;
        break;
      end
      if (instr_stall_sl) stall_n++;
    end
    chk("ready_timeout", {31'h0, got}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hi", {16'h0, hi}, 32'h0);
    chk("rst_lo", {16'h0, lo}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_div_zero", {31'h0, div_zero}, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // multu 300*500 = 0x000249F0, with stall length and pulse width
    start_op(2'b00, 16'd300, 16'd500, 1, 16'h0002, 16'h49F0, 1'b0);
    wait_ready();
    chk("stall_cycles", stall_n, 32'd18);
    chk("stall_low_in_ready", {31'h0, instr_stall_sl}, 32'h0);
    @(negedge clock);
    chk("ready_one_cycle", {31'h0, ready}, 32'h0);

    // mult -3*7 and the 0x8000*0x8000 corner
    start_op(2'b10, 16'hFFFD, 16'd7, 1, 16'hFFFF, 16'hFFEB, 1'b0);
    wait_ready();
    start_op(2'b10, 16'h8000, 16'h8000, 1, 16'h4000, 16'h0000, 1'b0);
    wait_ready();

    // divu 100/7 and div -100/7
    start_op(2'b01, 16'd100, 16'd7, 1, 16'd2, 16'd14, 1'b0);
    wait_ready();
    start_op(2'b11, 16'hFF9C, 16'd7, 1, 16'hFFFE, 16'hFFF2, 1'b0);
    wait_ready();

    // Divide by zero, unsigned and signed; sticky until next start edge
    start_op(2'b11, 16'hFF9C, 16'd0, 1, 16'hFF9C, 16'hFFFF, 1'b1);
    wait_ready();
    start_op(2'b01, 16'd1234, 16'd0, 1, 16'h04D2, 16'hFFFF, 1'b1);
    wait_ready();
    repeat (3) @(negedge clock);
    chk("div_zero_sticky", {31'h0, div_zero}, 32'd1);
    start_op(2'b00, 16'd5, 16'd5, 1, 16'h0000, 16'd25, 1'b0);
    chk("div_zero_clr_on_start", {31'h0, div_zero}, 32'h0);
    wait_ready();

    // Start toggling and operand changes while busy are ignored
    start_op(2'b00, 16'd2, 16'd3, 1, 16'h0000, 16'd6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      start = ~start;
      a = 16'($urandom);
      b = 16'($urandom);
      op = 2'($urandom);
    end
    start = 1'b0;
    wait_ready();

    // Back-to-back: start issued in the ready cycle is accepted
    start_op(2'b01, 16'd9, 16'd2, 1, 16'd1, 16'd4, 1'b0);
    wait_ready();

    // Reset mid-operation aborts; no ready follows, HI/LO cleared
    @(negedge clock);
    start_op(2'b01, 16'd100, 16'd7, 0, 16'h0, 16'h0, 1'b0);
    repeat (8) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_stall", {31'h0, instr_stall_sl}, 32'h0);
    chk("abort_hi", {16'h0, hi}, 32'h0);
    chk("abort_lo", {16'h0, lo}, 32'h0);
    chk("abort_ready", {31'h0, ready}, 32'h0);
    reset = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
